// File: rtl/alu_result_stage_if.sv
// Handshake/data bundle around alu_result_stage.
// Upstream side: ALU result + flags (in_*); downstream side: buffered entry (out_*).
// The stage itself connects through the slave modport; the driver/consumer uses master.
interface alu_result_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [2:0]       in_op;
  logic             in_cout;
  logic             in_overflow;
  logic             in_zero;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_op;
  logic             out_cout;
  logic             out_overflow;
  logic             out_zero;
  logic             out_neg;

  modport slave (
    input  in_valid, in_result, in_op, in_cout, in_overflow, in_zero,
    output in_ready,
    output out_valid, out_result, out_op, out_cout, out_overflow, out_zero, out_neg,
    input  out_ready
  );

  modport master (
    output in_valid, in_result, in_op, in_cout, in_overflow, in_zero,
    input  in_ready,
    input  out_valid, out_result, out_op, out_cout, out_overflow, out_zero, out_neg,
    output out_ready
  );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: two-entry (head + skid) pipeline register behind the sliced ALU.
// Qualifies overflow by opcode at capture and counts retired operations.
// Optional feature macro: ALU_STICKY_OVF_EN adds a sticky overflow status bit
// (set on retiring an overflowing entry, cleared by clr_sticky, set wins).
//
// state   | meaning
// --------+---------------------------------------------
// S_EMPTY | no valid entry
// S_ONE   | head valid, skid empty
// S_TWO   | head and skid valid, in_ready held low
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_result_stage_if.slave bus,
  output logic [CNT_W-1:0]  ops_retired,
  input  logic              clr_sticky,
  output logic              sticky_ovf
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [2:0]       op;
    logic             cout;
    logic             ovf;
    logic             zero;
  } entry_t;

  state_t           r_state;
  state_t           w_next_state;
  entry_t           r_head;
  entry_t           r_skid;
  entry_t           w_incoming;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_ops_retired;
  logic             w_push;
  logic             w_pop;
  logic             w_load_head;
  logic             w_head_from_skid;
  logic             w_load_skid;

  assign w_push = bus.in_valid & r_in_ready;
  assign w_pop  = r_out_valid & bus.out_ready;

  // Only arithmetic ops (op[1]=1) can overflow; logical ops force the flag low.
  assign w_incoming.result = bus.in_result;
  assign w_incoming.op     = bus.in_op;
  assign w_incoming.cout   = bus.in_cout;
  assign w_incoming.ovf    = bus.in_overflow & bus.in_op[1];
  assign w_incoming.zero   = bus.in_zero;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_next_state;
  end

  // Next-state and entry-load decisions.
  always_comb begin
    w_next_state     = r_state;
    w_load_head      = 1'b0;
    w_head_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_next_state = S_ONE;
          w_load_head  = 1'b1;
        end
      end
      S_ONE: begin
        case ({w_push, w_pop})
          2'b10: begin
            w_next_state = S_TWO;
            w_load_skid  = 1'b1;
          end
          2'b01: w_next_state = S_EMPTY;
          2'b11: begin
            w_next_state = S_ONE;
            w_load_head  = 1'b1;
          end
          default: w_next_state = S_ONE;
        endcase
      end
      S_TWO: begin
        if (w_pop) begin
          w_next_state     = S_ONE;
          w_load_head      = 1'b1;
          w_head_from_skid = 1'b1;
        end
      end
      default: w_next_state = S_EMPTY;
    endcase
  end

  // Registered handshake outputs derived from the next state, so in_ready
  // never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_out_valid <= (w_next_state != S_EMPTY);
      r_in_ready  <= (w_next_state != S_TWO);
    end
  end

  // Head/skid entry storage; head holds its value when not reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_head) r_head <= w_head_from_skid ? r_skid : w_incoming;
      if (w_load_skid) r_skid <= w_incoming;
    end
  end

  // Retired-operation counter, wraps silently.
  always_ff @(posedge clk) begin
    if (rst)        r_ops_retired <= '0;
    else if (w_pop) r_ops_retired <= r_ops_retired + 1'b1;
  end

`ifdef ALU_STICKY_OVF_EN
  logic r_sticky_ovf;

  // Sticky overflow: a retiring overflow beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                      r_sticky_ovf <= 1'b0;
    else if (w_pop & r_head.ovf)  r_sticky_ovf <= 1'b1;
    else if (clr_sticky)          r_sticky_ovf <= 1'b0;
  end

  assign sticky_ovf = r_sticky_ovf;
`else
  logic w_unused_clr_sticky;
  assign w_unused_clr_sticky = clr_sticky;
  assign sticky_ovf          = 1'b0;
`endif

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_result   = r_head.result;
  assign bus.out_op       = r_head.op;
  assign bus.out_cout     = r_head.cout;
  assign bus.out_overflow = r_head.ovf;
  assign bus.out_zero     = r_head.zero;
  assign bus.out_neg      = r_head.result[WIDTH-1];
  assign ops_retired      = r_ops_retired;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (CNT_W=4 so the counter wrap is reachable).
module tb_alu_result_stage;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
`ifdef ALU_STICKY_OVF_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             clr_sticky;
  logic             sticky_ovf;
  logic [CNT_W-1:0] ops_retired;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

  alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ops_retired (ops_retired),
    .clr_sticky  (clr_sticky),
    .sticky_ovf  (sticky_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic [31:0] res, input logic [2:0] op,
                          input logic cout, input logic ovf, input logic zero);
    bus.in_valid    = v;
    bus.in_result   = res;
    bus.in_op       = op;
    bus.in_cout     = cout;
    bus.in_overflow = ovf;
    bus.in_zero     = zero;
  endtask

  initial begin
    rst           = 1'b1;
    clr_sticky    = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);

    // 1. reset
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_ops", ops_retired, 0);
    chk("rst_sticky", sticky_ovf, 0);
    rst = 1'b0;

    // 2. single entry
    drive_in(1'b1, 32'h5, 3'b010, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    drive_in(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("single_valid", bus.out_valid, 1);
    chk("single_result", bus.out_result, 32'h5);
    chk("single_ops_before", ops_retired, 0);
    tick();
    chk("single_ops_after", ops_retired, 1);
    chk("single_empty", bus.out_valid, 0);

    // 3. back-pressure
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h11, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_ready_after1", bus.in_ready, 1);
    drive_in(1'b1, 32'h22, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_ready_after2", bus.in_ready, 0);
    chk("bp_head_11", bus.out_result, 32'h11);
    drive_in(1'b1, 32'h33, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_still_full", bus.in_ready, 0);
    chk("bp_head_hold", bus.out_result, 32'h11);
    drive_in(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_drain_22", bus.out_result, 32'h22);
    chk("bp_drain_valid", bus.out_valid, 1);
    chk("bp_ready_back", bus.in_ready, 1);
    tick();
    chk("bp_drained", bus.out_valid, 0);
    chk("bp_ops", ops_retired, 3);

    // 4. overflow qualification and flag pass-through
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h8000_0000, 3'b010, 1'b0, 1'b1, 1'b0);
    tick();
    chk("ovf_add", bus.out_overflow, 1);
    chk("ovf_neg", bus.out_neg, 1);
    chk("ovf_result", bus.out_result, 32'h8000_0000);
    drive_in(1'b1, 32'h8000_0000, 3'b000, 1'b1, 1'b1, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    drive_in(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("ovf_and_masked", bus.out_overflow, 0);
    chk("ovf_and_op", bus.out_op, 3'b000);
    chk("ovf_cout_pass", bus.out_cout, 1);
    chk("ovf_zero_pass", bus.out_zero, 1);
    chk("ovf_ops", ops_retired, 4);
    chk("ovf_sticky", sticky_ovf, STICKY);
    tick();
    chk("ovf_ops_done", ops_retired, 5);

    // 6. sticky overflow
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky_clr", sticky_ovf, 0);
    drive_in(1'b1, 32'h7FFF_FFFF, 3'b110, 1'b1, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    tick();
    drive_in(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("sub_ovf", bus.out_overflow, 1);
    bus.out_ready = 1'b1;
    clr_sticky    = 1'b1;
    tick();
    chk("sticky_set_wins", sticky_ovf, STICKY);
    chk("sticky_ops", ops_retired, 6);
    tick();
    clr_sticky = 1'b0;
    chk("sticky_clr_alone", sticky_ovf, 0);

    // 5. counter wrap from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrap_ops_zero", ops_retired, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive_in(1'b1, 32'h100 + i, 3'b010, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("wrap_last_head", bus.out_result, 32'h110);
    drive_in(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wrap_ops", ops_retired, 1);
    chk("wrap_empty", bus.out_valid, 0);

    // reset with two entries buffered
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'hA, 3'b010, 1'b0, 1'b1, 1'b0);
    tick();
    drive_in(1'b1, 32'hB, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    drive_in(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("full_before_rst", bus.in_ready, 0);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_ops", ops_retired, 0);
    chk("midrst_ready", bus.in_ready, 1);
    chk("midrst_sticky", sticky_ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
